// File: rtl/mem_port.sv
// mem_port: CPU-side memory access port with a programmable number of wait
// states in front of a synchronous-write / combinational-read RAM.
//
// Each request goes through IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE
// (1 cycle). An out-of-range request goes straight from IDLE to DONE and
// raises fault.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   req           in   access request, sampled only in IDLE
//   cpu_address   in   [15:31] word address
//   cpu_wr_en     in   [0:3]   byte-lane write enables, all zero = read
//   cpu_wdata     in   [0:31]  write data
//   cpu_rdata     out  [0:31]  registered read data
//   ready         out  one-cycle completion pulse
//   fault         out  one-cycle out-of-range pulse, coincident with ready
//   busy          out  high whenever the FSM is not in IDLE
//   mem_address   out  [15:31] RAM address, latched value during ACCESS
//   mem_write_en  out  [0:3]   RAM byte strobes, final ACCESS cycle only
//   mem_wdata     out  [0:31]  RAM write data, latched value during ACCESS
//   mem_rdata     in   [0:31]  combinational RAM read data
//   access_count  out  [15:0]  completed non-faulting accesses (wraps)
//
// Bit numbering is ascending: bit 0 is the MSB. Byte lane i covers data
// bits [8*i : 8*i+7], so lane 0 is the most significant byte.
//
// COUNT_RESET is the value access_count takes in reset. It is 0 in normal
// use; a nonzero value lets the counter wrap be exercised quickly.
module mem_port #(
    parameter int unsigned WAIT_STATES  = 2,
    parameter int unsigned MAX_WORD_LEN = 1024,
    parameter logic [15:0] COUNT_RESET  = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic [15:31] cpu_address,
    input  logic [0:3]   cpu_wr_en,
    input  logic [0:31]  cpu_wdata,
    output logic [0:31]  cpu_rdata,
    output logic         ready,
    output logic         fault,
    output logic         busy,
    output logic [15:31] mem_address,
    output logic [0:3]   mem_write_en,
    output logic [0:31]  mem_wdata,
    input  logic [0:31]  mem_rdata,
    output logic [15:0]  access_count
);

    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [16:0] ADDR_LIMIT = 17'(MAX_WORD_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:31]  addr_q, addr_d;
    logic [0:3]    wen_q, wen_d;
    logic [0:31]   wdata_q, wdata_d;
    logic [3:0]    wait_q, wait_d;
    logic [0:31]   cpu_rdata_q, cpu_rdata_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;
    logic          busy_q, busy_d;
    logic [15:31]  mem_address_q, mem_address_d;
    logic [0:3]    mem_write_en_q, mem_write_en_d;
    logic [0:31]   mem_wdata_q, mem_wdata_d;
    logic [15:0]   access_count_q, access_count_d;
    logic          out_of_range;

    assign out_of_range = (cpu_address >= ADDR_LIMIT);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wait_d         = wait_q;
        cpu_rdata_d    = cpu_rdata_q;
        access_count_d = access_count_q;
        fault_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = cpu_address;
                    wen_d   = cpu_wr_en;
                    wdata_d = cpu_wdata;
                    wait_d  = WAIT_INIT;
                    if (out_of_range) begin
                        state_d     = S_DONE;
                        fault_d     = 1'b1;
                        cpu_rdata_d = '0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q == 4'd0) begin
                    // This edge ends the final ACCESS cycle: the RAM read
                    // data is valid now, and the write strobe has just been
                    // issued.
                    state_d        = S_DONE;
                    access_count_d = access_count_q + 16'd1;
                    if (wen_q == 4'b0000) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // All outputs are registered, so they are derived from next state.
        ready_d        = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        mem_address_d  = (state_d == S_ACCESS) ? addr_d  : '0;
        mem_wdata_d    = (state_d == S_ACCESS) ? wdata_d : '0;
        mem_write_en_d = (state_d == S_ACCESS && wait_d == 4'd0) ? wen_d : 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            wen_q          <= '0;
            wdata_q        <= '0;
            wait_q         <= '0;
            cpu_rdata_q    <= '0;
            ready_q        <= 1'b0;
            fault_q        <= 1'b0;
            busy_q         <= 1'b0;
            mem_address_q  <= '0;
            mem_write_en_q <= '0;
            mem_wdata_q    <= '0;
            access_count_q <= COUNT_RESET;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wen_q          <= wen_d;
            wdata_q        <= wdata_d;
            wait_q         <= wait_d;
            cpu_rdata_q    <= cpu_rdata_d;
            ready_q        <= ready_d;
            fault_q        <= fault_d;
            busy_q         <= busy_d;
            mem_address_q  <= mem_address_d;
            mem_write_en_q <= mem_write_en_d;
            mem_wdata_q    <= mem_wdata_d;
            access_count_q <= access_count_d;
        end
    end

    assign cpu_rdata    = cpu_rdata_q;
    assign ready        = ready_q;
    assign fault        = fault_q;
    assign busy         = busy_q;
    assign mem_address  = mem_address_q;
    assign mem_wdata    = mem_wdata_q;
    assign access_count = access_count_q;
    // Reset pulled low during the final ACCESS cycle must also suppress the
    // strobe already on the bus, so the write never lands in the RAM.
    assign mem_write_en = reset ? mem_write_en_q : 4'b0000;

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter WAIT_STATES, default 2, extra memory cycles per access (legal 0..15).
REQ-002 Parameter MAX_WORD_LEN, default 1024, number of implemented words; power of two.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-005 req  input  1  CPU access request, sampled only in IDLE.
REQ-006 cpu_address  input  17 [15:31]  CPU word address.
REQ-007 cpu_wr_en  input  4 [0:3]  byte-lane write enables; all zero = read.
REQ-008 cpu_wdata  input  32 [0:31]  CPU write data.
REQ-009 cpu_rdata  output  32 [0:31]  registered read data to CPU.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 fault  output  1  one-cycle out-of-range pulse, coincident with ready.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 mem_address  output  17 [15:31]  address to RAM.
REQ-014 mem_write_en  output  4 [0:3]  byte-lane write strobes to RAM.
REQ-015 mem_wdata  output  32 [0:31]  write data to RAM.
REQ-016 mem_rdata  input  32 [0:31]  combinational read data from RAM.
REQ-017 access_count  output  16  completed non-faulting accesses, wraps 0xFFFF -> 0x0000.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-019 IDLE with req=1 SHALL latch cpu_address, cpu_wr_en, cpu_wdata and load wait counter with WAIT_STATES.
REQ-020 IDLE with req=1 and cpu_address >= MAX_WORD_LEN SHALL go to DONE with fault=1 and cpu_rdata=0 in DONE, no RAM write.
REQ-021 IDLE with req=1 and in-range address SHALL go to ACCESS.
REQ-022 ACCESS SHALL last exactly WAIT_STATES+1 cycles; counter decrements each cycle; leave when counter is 0.
REQ-023 mem_address and mem_wdata SHALL drive latched values throughout ACCESS; 0 in IDLE/DONE.
REQ-024 mem_write_en SHALL equal latched enables only in final ACCESS cycle, 4'b0000 otherwise; exactly one write strobe per access.
REQ-025 Read (latched enables all zero) SHALL capture mem_rdata into cpu_rdata at edge ending final ACCESS cycle; writes leave cpu_rdata unchanged.
REQ-026 DONE SHALL last one cycle with ready=1, then go to IDLE; access_count increments on entry to DONE unless fault.
REQ-027 Latency: req sampled at edge N, in-range -> ready high in cycle following edge N+WAIT_STATES+1; fault -> ready high in cycle following edge N.
REQ-028 req SHALL be ignored in ACCESS and DONE; CPU changes to cpu_* inputs during busy SHALL not affect the in-flight access.
REQ-029 Back-to-back in-range accesses with req held high SHALL complete every WAIT_STATES+3 cycles.
REQ-030 cpu_rdata SHALL hold its value until the next completed read or fault.

Reset
REQ-031 reset=0 at a rising edge SHALL force IDLE; ready=0, fault=0, busy=0, cpu_rdata=0, access_count=0, mem_write_en=0, mem_address=0, mem_wdata=0.
REQ-032 reset asserted during ACCESS SHALL abort the access with no mem_write_en pulse in that or any later cycle.
REQ-033 Latched request state SHALL be discarded by reset; first req after reset release accepted on the first edge with reset=1.

Verification
REQ-034 WAIT_STATES=2, write addr 0x010, en 4'b1111, data 0xDEADBEEF -> one mem_write_en=1111 pulse 3 cycles after accept, ready next cycle, access_count=1.
REQ-035 Then read addr 0x010 -> cpu_rdata=0xDEADBEEF with ready, mem_write_en stays 0000.
REQ-036 Write addr 0x011, en 4'b0100, data 0x00AB0000 over RAM 0x11223344 -> read returns 0x11AB3344.
REQ-037 req addr 0x0400 (MAX_WORD_LEN=1024) -> ready and fault on cycle after accept, cpu_rdata=0, no write, access_count unchanged.
REQ-038 Assert reset in 2nd ACCESS cycle of write to 0x020 -> no write strobe, RAM 0x020 unchanged, all outputs at reset values.
REQ-039 WAIT_STATES=0, req held high for 4 accesses -> ready every 3 cycles; access_count 0xFFFF preload path -> wraps to 0x0000.
